count_seq_check: RTL and testbench

COUNT_SEQ_CHECK -- requirements
Module: count_seq_check

---
 rtl/count_seq_check_pkg.sv | 22 ++
 rtl/count_seq_check_seq_next_val.sv | 26 ++
 rtl/count_seq_check.sv | 144 ++++++++++++++
 tb/tb_count_seq_check.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_check_pkg.sv
// Shared definitions for the count sequence checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package count_seq_check_pkg;

   // Checker state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   // Width of the monitored count bus
   localparam int CNT_W = 3;

   // Default parameter values
   localparam int DEF_MODULUS  = 6;
   localparam int DEF_LOCK_CNT = 3;
   localparam int DEF_TIMEOUT  = 20;
   localparam int DEF_ERR_W    = 8;

endpackage

// File: rtl/count_seq_check_seq_next_val.sv
// Expected-successor and range check for a mod-MODULUS count value.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs directly.
module seq_next_val
   import count_seq_check_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic [CNT_W-1:0] prev,
   input  logic [CNT_W-1:0] val,
   output logic             in_range,
   output logic             legal,
   output logic             is_wrap
);

   // One bit wider than the bus so prev=7 expects 8 and can never alias onto 0.
   logic [CNT_W:0] exp_val;
   logic           prev_top;

   assign prev_top = (prev == CNT_W'(MODULUS - 1));
   assign exp_val  = prev_top ? '0 : ({1'b0, prev} + (CNT_W+1)'(1));
   assign in_range = ({1'b0, val} < (CNT_W+1)'(MODULUS));
   assign legal    = in_range && ({1'b0, val} == exp_val);
   assign is_wrap  = legal && prev_top;

endmodule

// File: rtl/count_seq_check.sv
// Verifies a mod-MODULUS counter steps by one, tracking lock, errors, stalls and wraps.
// Latency: every output is registered; pulses appear the cycle after the causing edge.
// Backpressure: none; en=0 freezes all tracking state and suppresses pulses.
module count_seq_check
   import count_seq_check_pkg::*;
#(
   parameter int MODULUS  = DEF_MODULUS,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int ERR_W    = DEF_ERR_W
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       cnt_in,
   output logic             locked,
   output logic             err_pulse,
   output logic             stall_pulse,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] wrap_cnt
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] prev, prev_nx;
   logic [GW-1:0]    good, good_nx, good_inc;
   logic [TW-1:0]    tcnt, tcnt_nx, tcnt_inc;
   logic             chg;
   logic             in_range, legal, is_wrap;
   logic             err_ev, stall_ev, wrap_ev;

   seq_next_val #(.MODULUS(MODULUS)) u_next (
      .prev     (prev),
      .val      (cnt_in),
      .in_range (in_range),
      .legal    (legal),
      .is_wrap  (is_wrap)
   );

   assign chg      = (cnt_in != prev);
   assign good_inc = good + GW'(1);
   assign tcnt_inc = tcnt + TW'(1);

   // Next-state and event decode; a value change always wins over timeout expiry.
   always_comb begin
      state_nx = state;
      prev_nx  = prev;
      good_nx  = good;
      tcnt_nx  = tcnt;
      err_ev   = 1'b0;
      stall_ev = 1'b0;
      wrap_ev  = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               prev_nx = cnt_in;
               if (in_range) begin
                  state_nx = SYNC;
                  good_nx  = '0;
               end else begin
                  err_ev = 1'b1;
               end
            end
            SYNC: begin
               if (chg) begin
                  prev_nx = cnt_in;
                  tcnt_nx = '0;
                  if (legal) begin
                     wrap_ev = is_wrap;
                     if (good_inc == GW'(LOCK_CNT)) begin
                        state_nx = LOCK;
                        good_nx  = '0;
                     end else begin
                        good_nx = good_inc;
                     end
                  end else begin
                     good_nx = '0;
                  end
               end
            end
            LOCK: begin
               if (chg) begin
                  prev_nx = cnt_in;
                  tcnt_nx = '0;
                  if (legal) begin
                     wrap_ev = is_wrap;
                  end else begin
                     err_ev   = 1'b1;
                     state_nx = SYNC;
                     good_nx  = '0;
                  end
               end else if (tcnt_inc == TW'(TIMEOUT)) begin
                  stall_ev = 1'b1;
                  state_nx = SYNC;
                  good_nx  = '0;
                  tcnt_nx  = '0;
               end else begin
                  tcnt_nx = tcnt_inc;
               end
            end
            default: begin
               state_nx = IDLE;
               good_nx  = '0;
               tcnt_nx  = '0;
            end
         endcase
      end
   end

   // State, history and registered outputs; reset discards all history.
   always_ff @(posedge mclk) begin
      if (rst) begin
         state       <= IDLE;
         prev        <= '0;
         good        <= '0;
         tcnt        <= '0;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         stall_pulse <= 1'b0;
         wrap_pulse  <= 1'b0;
         err_cnt     <= '0;
         wrap_cnt    <= '0;
      end else begin
         state       <= state_nx;
         prev        <= prev_nx;
         good        <= good_nx;
         tcnt        <= tcnt_nx;
         locked      <= (state_nx == LOCK);
         err_pulse   <= err_ev;
         stall_pulse <= stall_ev;
         wrap_pulse  <= wrap_ev;
         if ((err_ev || stall_ev) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
         end
         if (wrap_ev) begin
            wrap_cnt <= wrap_cnt + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_count_seq_check.sv
// Randomized and directed bench for count_seq_check against a behavioural model.
// Latency: model expectations reflect the cycle after each sampling edge.
// Backpressure: n/a.
module tb_count_seq_check;

   localparam int MOD = 6;
   localparam int LCK = 3;
   localparam int TMO = 20;
   localparam int EW  = 8;
   localparam int CMAX = (1 << EW) - 1;

   logic          mclk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [2:0]    cnt_in = 3'd0;
   logic          locked, err_pulse, stall_pulse, wrap_pulse;
   logic [EW-1:0] err_cnt, wrap_cnt;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   // model state
   bit have_prev = 1'b0;
   bit m_lock = 1'b0;
   int m_prev = 0;
   int run = 0;
   int quiet = 0;
   int v;
   bit legal;
   bit e_locked = 1'b0, e_err = 1'b0, e_stall = 1'b0, e_wrap = 1'b0;
   int e_errcnt = 0, e_wrapcnt = 0;

   count_seq_check #(.MODULUS(MOD), .LOCK_CNT(LCK), .TIMEOUT(TMO), .ERR_W(EW)) dut (
      .mclk        (mclk),
      .rst         (rst),
      .en          (en),
      .cnt_in      (cnt_in),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .stall_pulse (stall_pulse),
      .wrap_pulse  (wrap_pulse),
      .err_cnt     (err_cnt),
      .wrap_cnt    (wrap_cnt)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: track the run of good steps, lock and quiet time.
   always @(posedge mclk) begin
      e_err = 1'b0;
      e_stall = 1'b0;
      e_wrap = 1'b0;
      if (rst) begin
         have_prev = 1'b0;
         m_prev = 0;
         m_lock = 1'b0;
         run = 0;
         quiet = 0;
         e_errcnt = 0;
         e_wrapcnt = 0;
         e_locked = 1'b0;
      end else if (en) begin
         v = int'(cnt_in);
         if (!have_prev) begin
            m_prev = v;
            if (v < MOD) begin
               have_prev = 1'b1;
               run = 0;
            end else begin
               e_err = 1'b1;
            end
         end else if (v != m_prev) begin
            legal = (v < MOD) && (v == ((m_prev == MOD - 1) ? 0 : m_prev + 1));
            if (legal && m_prev == MOD - 1) e_wrap = 1'b1;
            if (m_lock) begin
               quiet = 0;
               if (!legal) begin
                  e_err = 1'b1;
                  m_lock = 1'b0;
                  run = 0;
               end
            end else begin
               run = legal ? run + 1 : 0;
               if (run == LCK) begin
                  m_lock = 1'b1;
                  run = 0;
                  quiet = 0;
               end
            end
            m_prev = v;
         end else if (m_lock) begin
            quiet++;
            if (quiet == TMO) begin
               e_stall = 1'b1;
               m_lock = 1'b0;
               run = 0;
               quiet = 0;
            end
         end
         if ((e_err || e_stall) && e_errcnt < CMAX) e_errcnt++;
         if (e_wrap) e_wrapcnt = (e_wrapcnt + 1) % (CMAX + 1);
         e_locked = m_lock;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge mclk) begin
      if (chk_on) begin
         chk("locked", int'(locked), int'(e_locked));
         chk("err_pulse", int'(err_pulse), int'(e_err));
         chk("stall_pulse", int'(stall_pulse), int'(e_stall));
         chk("wrap_pulse", int'(wrap_pulse), int'(e_wrap));
         chk("err_cnt", int'(err_cnt), e_errcnt);
         chk("wrap_cnt", int'(wrap_cnt), e_wrapcnt);
      end
   end

   task automatic step(input logic r, input logic e, input int val);
      @(negedge mclk);
      rst = r;
      en = e;
      cnt_in = 3'(val);
      @(posedge mclk);
      #1;
   endtask

   task automatic hold(input int val, input int n);
      repeat (n) step(1'b0, 1'b1, val);
   endtask

   initial begin
      int cur;
      int p;
      int q;
      int n;

      // reset
      step(1'b1, 1'b1, 5);
      step(1'b1, 1'b0, 0);
      chk_on = 1'b1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);

      // acquire lock with 0,1,2,3
      hold(0, 10);
      hold(1, 10);
      hold(2, 10);
      chk("acq_not_yet", int'(locked), 0);
      step(1'b0, 1'b1, 3);
      chk("acq_locked", int'(locked), 1);
      hold(3, 9);
      chk("acq_err_cnt", int'(err_cnt), 0);

      // wrap while locked
      step(1'b0, 1'b1, 4);
      step(1'b0, 1'b1, 5);
      step(1'b0, 1'b1, 0);
      chk("wrap_pulse", int'(wrap_pulse), 1);
      chk("wrap_cnt1", int'(wrap_cnt), 1);
      chk("wrap_locked", int'(locked), 1);
      step(1'b0, 1'b1, 0);
      chk("wrap_pulse_end", int'(wrap_pulse), 0);

      // illegal jump 2->4 while locked, then relock
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 2);
      step(1'b0, 1'b1, 4);
      chk("jump_err_pulse", int'(err_pulse), 1);
      chk("jump_err_cnt", int'(err_cnt), 1);
      chk("jump_unlocked", int'(locked), 0);
      step(1'b0, 1'b1, 4);
      chk("jump_pulse_end", int'(err_pulse), 0);
      step(1'b0, 1'b1, 5);
      step(1'b0, 1'b1, 0);
      chk("relock_not_yet", int'(locked), 0);
      step(1'b0, 1'b1, 1);
      chk("relock", int'(locked), 1);
      chk("relock_wrap_cnt", int'(wrap_cnt), 2);

      // stall: hold value 20 cycles while locked
      hold(1, 19);
      chk("stall_early", int'(stall_pulse), 0);
      chk("stall_early_lock", int'(locked), 1);
      step(1'b0, 1'b1, 1);
      chk("stall_pulse", int'(stall_pulse), 1);
      chk("stall_err_cnt", int'(err_cnt), 2);
      chk("stall_unlocked", int'(locked), 0);

      // relock, then en=0 freezes everything including the timeout
      step(1'b0, 1'b1, 2);
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 4);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, $urandom_range(0, 7));
      chk("en_low_locked", int'(locked), 1);
      chk("en_low_err_cnt", int'(err_cnt), 2);
      step(1'b0, 1'b1, 5);
      chk("en_resume_locked", int'(locked), 1);

      // out-of-range value in IDLE, then reacquire from 1
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b1, 7);
      chk("idle_err_pulse", int'(err_pulse), 1);
      chk("idle_err_cnt", int'(err_cnt), 1);
      step(1'b0, 1'b1, 1);
      chk("idle_to_sync", int'(err_pulse), 0);
      step(1'b0, 1'b1, 2);
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 4);
      chk("idle_relock", int'(locked), 1);

      // reset while locked with err_cnt=5 and a wrap recorded
      step(1'b1, 1'b1, 0);
      hold(7, 5);
      hold(0, 1);
      hold(1, 1);
      hold(2, 1);
      hold(3, 1);
      hold(4, 1);
      hold(5, 1);
      hold(0, 1);
      chk("pre_rst_err_cnt", int'(err_cnt), 5);
      chk("pre_rst_wrap_cnt", int'(wrap_cnt), 1);
      chk("pre_rst_locked", int'(locked), 1);
      step(1'b1, 1'b1, 1);
      chk("rst_mid_locked", int'(locked), 0);
      chk("rst_mid_err_cnt", int'(err_cnt), 0);
      chk("rst_mid_wrap_cnt", int'(wrap_cnt), 0);

      // err_cnt saturation
      hold(7, 260);
      chk("sat_err_cnt", int'(err_cnt), 255);
      chk("sat_err_pulse", int'(err_pulse), 1);

      // wrap_cnt rolls over: 260 passes of 0..5 give 259 wraps
      step(1'b1, 1'b1, 0);
      for (int k = 0; k < 260; k++) begin
         for (int j = 0; j < MOD; j++) step(1'b0, 1'b1, j);
      end
      chk("wrap_rollover", int'(wrap_cnt), 3);
      chk("wrap_roll_locked", int'(locked), 1);

      // randomized traffic
      cur = 5;
      for (int i = 0; i < 3000; i++) begin
         p = $urandom_range(0, 99);
         if (p < 1) begin
            step(1'b1, 1'b1, cur);
         end else if (p < 3) begin
            n = $urandom_range(15, 25);
            repeat (n) step(1'b0, 1'b1, cur);
         end else begin
            q = $urandom_range(0, 99);
            if (q < 70) cur = (cur == MOD - 1) ? 0 : cur + 1;
            else if (q >= 85) cur = $urandom_range(0, 7);
            step(1'b0, ($urandom_range(0, 9) != 0), cur);
         end
      end

      @(negedge mclk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
